// File: rtl/b_minus_ka_seq.sv
// b_minus_ka_seq: sequential b - k*a, one multiplier bit per cycle.
// A start in IDLE or DONE captures a, b and k, then RUN spends exactly KW cycles
// subtracting the shifted a for each set bit of k. DONE lasts one cycle and presents
// the result.
// Optional build macro B_MINUS_KA_SAT_EN: clamp o to 0 when the result is negative.
module b_minus_ka_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             borrow
);

    // The accumulator is wide enough for b - (2^KW - 1) * a plus a sign bit.
    localparam int unsigned AW = WIDTH + KW + 1;
    localparam int unsigned CW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  a_sh_q, a_sh_d;  // captured a, pre-shifted for the current step
    logic [KW-1:0]         k_sh_q, k_sh_d;  // captured k, current bit in position 0
    logic [CW-1:0]         step_q, step_d;
    logic [WIDTH-1:0]      o_q, o_d;
    logic                  borrow_q, borrow_d;
    logic signed [AW-1:0]  acc_step;

    // State and datapath registers; reset clears everything, including the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            a_sh_q   <= '0;
            k_sh_q   <= '0;
            step_q   <= '0;
            o_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_sh_q   <= a_sh_d;
            k_sh_q   <= k_sh_d;
            step_q   <= step_d;
            o_q      <= o_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state logic: capture on start, one shift-subtract step per RUN cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_sh_d   = a_sh_q;
        k_sh_d   = k_sh_q;
        step_d   = step_q;
        o_d      = o_q;
        borrow_d = borrow_q;
        acc_step = k_sh_q[0] ? (acc_q - a_sh_q) : acc_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = {{(KW + 1){1'b0}}, b};
                    a_sh_d  = {{(KW + 1){1'b0}}, a};
                    k_sh_d  = k;
                    step_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q <<< 1;
                k_sh_d = k_sh_q >> 1;
                step_d = step_q + CW'(1);
                if (step_q == CW'(KW - 1)) begin
                    // o and borrow change only here, on the way into DONE.
                    state_d  = DONE;
                    borrow_d = acc_step[AW-1];
`ifdef B_MINUS_KA_SAT_EN
                    o_d = acc_step[AW-1] ? '0 : acc_step[WIDTH-1:0];
`else
                    o_d = acc_step[WIDTH-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status decoded straight from state so reset clears them immediately.
    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        o      = o_q;
        borrow = borrow_q;
    end

endmodule

// File: tb/tb_b_minus_ka_seq.sv
// Testbench for b_minus_ka_seq (WIDTH=16, KW=4): vector table plus scoreboard queue,
// and hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_b_minus_ka_seq;

    localparam int WIDTH = 16;
    localparam int KW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic [KW-1:0]    k;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] o;

    b_minus_ka_seq #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .k      (k),
        .busy   (busy),
        .done   (done),
        .o      (o),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] eo_wrap;
        logic [WIDTH-1:0] eo_sat;
        logic             eb;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] o;
        logic             borrow;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   tests     = 0;
    int   fails     = 0;
    int   done_seen = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: exact b - k*a in 32-bit signed arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [KW-1:0] mk, input string name);
        exp_t        e;
        int          diff;
        logic [31:0] d;
        diff     = int'(mb) - int'(mk) * int'(ma);
        d        = diff;
        e.borrow = (diff < 0);
        e.o      = d[WIDTH-1:0];
`ifdef B_MINUS_KA_SAT_EN
        if (e.borrow) e.o = '0;
`endif
        e.name = name;
        return e;
    endfunction

    function automatic exp_t from_vec(input vec_t v, input string name);
        exp_t e;
`ifdef B_MINUS_KA_SAT_EN
        e.o = v.eo_sat;
`else
        e.o = v.eo_wrap;
`endif
        e.borrow = v.eb;
        e.name   = name;
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 with o=0x%0h, expected no done", o);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_o"}, 32'(o), 32'(mon_e.o));
                check({mon_e.name, "_borrow"}, 32'(borrow), 32'(mon_e.borrow));
            end
        end
    end

    // Called at a negedge: present a start for the cycle in progress.
    task automatic drive_start(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                               input logic [KW-1:0] dk, input exp_t e, input bit push);
        start = 1'b1;
        a     = da;
        b     = db;
        k     = dk;
        if (push) exp_q.push_back(e);
    endtask

    task automatic scramble_inputs();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        k     = KW'($urandom);
    endtask

    // Full operation with latency, busy and hold checks; returns at a negedge.
    task automatic run_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                          input logic [KW-1:0] rk, input exp_t e);
        drive_start(ra, rb, rk, e, 1'b1);
        for (int c = 1; c <= KW + 1; c++) begin
            @(negedge clk);
            if (c == 1) scramble_inputs();
            if (c <= KW) begin
                check({e.name, "_busy_run"}, 32'(busy), 32'd1);
                check({e.name, "_done_early"}, 32'(done), 32'd0);
            end else begin
                check({e.name, "_done_lat"}, 32'(done), 32'd1);
                check({e.name, "_busy_done"}, 32'(busy), 32'd0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        check({e.name, "_done_pulse"}, 32'(done), 32'd0);
        check({e.name, "_o_hold"}, 32'(o), 32'(e.o));
    endtask

    initial begin
        int   d0;
        exp_t e;
        logic [WIDTH-1:0] ra, rb;
        logic [KW-1:0]    rk;

        //          a        b        k      wrap     sat      borrow
        vecs[0] = '{16'd3,    16'd10,   4'd2,  16'h0004, 16'h0004, 1'b0};
        vecs[1] = '{16'd10,   16'd3,    4'd2,  16'hFFEF, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 4'd15, 16'h000F, 16'h0000, 1'b1};
        vecs[3] = '{16'd7,    16'h1234, 4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[4] = '{16'd1,    16'd5,    4'd5,  16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'd1,    16'd5,    4'd6,  16'hFFFF, 16'h0000, 1'b1};
        vecs[6] = '{16'h0000, 16'hFFFF, 4'd15, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h1000, 16'hFFFF, 4'd15, 16'h0FFF, 16'h0FFF, 1'b0};
        vecs[8] = '{16'h8000, 16'h0000, 4'd1,  16'h8000, 16'h0000, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        k     = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_o", 32'(o), 32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e = from_vec(vecs[i], $sformatf("vec%0d", i));
            run_op(vecs[i].a, vecs[i].b, vecs[i].k, e);
        end

        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rk = KW'($urandom_range(0, 15));
            run_op(ra, rb, rk, model(ra, rb, rk, $sformatf("rnd%0d", i)));
        end

        // A start two cycles into RUN must be ignored: one done, original result.
        d0 = done_seen;
        drive_start(16'd3, 16'd100, 4'd3, model(16'd3, 16'd100, 4'd3, "ignore"), 1'b1);
        for (int c = 1; c <= KW + 1; c++) begin
            @(negedge clk);
            if (c == 2) drive_start(16'hFFFF, 16'd0, 4'd15, e, 1'b0);
            else        start = 1'b0;
            if (c == KW + 1) check("ignore_done_lat", 32'(done), 32'd1);
        end
        for (int c = 0; c < KW + 3; c++) @(negedge clk);
        check("ignore_done_count", 32'(done_seen - d0), 32'd1);

        // Start on the done cycle: second operation follows with no idle gap.
        drive_start(16'd2, 16'd50, 4'd4, model(16'd2, 16'd50, 4'd4, "b2b_first"), 1'b1);
        for (int c = 1; c <= KW + 1; c++) begin
            @(negedge clk);
            if (c == 1) scramble_inputs();
        end
        check("b2b_first_done", 32'(done), 32'd1);
        drive_start(16'd5, 16'h0100, 4'd9, model(16'd5, 16'h0100, 4'd9, "b2b_second"), 1'b1);
        @(negedge clk);
        scramble_inputs();
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        for (int c = 2; c <= KW + 1; c++) @(negedge clk);
        check("b2b_second_done", 32'(done), 32'd1);
        @(negedge clk);

        // Reset during RUN cycle 2: outputs clear at once, aborted op never completes.
        d0 = done_seen;
        drive_start(16'd1, 16'd9, 4'd15, e, 1'b0);
        @(negedge clk);
        scramble_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_o", 32'(o), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < KW + 3; c++) @(negedge clk);
        check("rst_no_done", 32'(done_seen - d0), 32'd0);
        run_op(16'd6, 16'd20, 4'd3, model(16'd6, 16'd20, 4'd3, "post_rst"));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1);
    end

endmodule

// File: doc/b_minus_ka_seq.md
B_MINUS_KA_SEQ -- requirements
Module: b_minus_ka_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have parameter KW, default 4, meaning the multiplier width in bits (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset; the reset is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin one operation.
REQ-006 The block SHALL have port a, input, WIDTH bits, unsigned subtrahend base.
REQ-007 The block SHALL have port b, input, WIDTH bits, unsigned minuend.
REQ-008 The block SHALL have port k, input, KW bits, unsigned multiplier applied to a.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port o, output, WIDTH bits, the result of b - k*a.
REQ-012 The block SHALL have port borrow, output, 1 bit, high when the exact b - k*a is negative.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture a, b and k into internal registers and enter RUN.
REQ-015 RUN SHALL last exactly KW cycles; in step i (0..KW-1), if captured k[i]=1, the accumulator SHALL be reduced by (a << i).
REQ-016 The accumulator SHALL be signed, WIDTH+KW+1 bits wide, initialised to zero-extended b, so that no intermediate result is lost.
REQ-017 After the final RUN step the block SHALL enter DONE for one cycle: done=1, busy=0; it then returns to IDLE unless start=1 per REQ-014.
REQ-018 Latency: done SHALL assert exactly KW+1 cycles after the edge that samples start.
REQ-019 busy SHALL be 1 in RUN only.
REQ-020 o and borrow SHALL update only when entering DONE and SHALL hold until the next DONE or reset.
REQ-021 borrow SHALL equal the accumulator sign bit at completion.
REQ-022 start while busy=1 SHALL be ignored; inputs a, b and k are don't-care outside the capture edge.
REQ-023 k=0 SHALL yield o=b, borrow=0 after the full KW+1 latency (no early exit).

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, o=0, borrow=0, accumulator=0.
REQ-025 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro B_MINUS_KA_SAT_EN defined: when borrow=1, o SHALL be clamped to 0.
REQ-027 Macro B_MINUS_KA_SAT_EN undefined: o SHALL be the accumulator's low WIDTH bits (wrap modulo 2^WIDTH); borrow SHALL behave identically in both builds.

Verification (WIDTH=16, KW=4)
REQ-028 Scenario: a=3, b=10, k=2, start pulse -> done 5 cycles later, o=0x0004, borrow=0.
REQ-029 Scenario: a=10, b=3, k=2 -> o=0xFFEF, borrow=1 (with B_MINUS_KA_SAT_EN: o=0x0000, borrow=1).
REQ-030 Scenario: a=0xFFFF, b=0x0000, k=15 -> o=0x000F, borrow=1 without the saturation macro; o=0x0000 with it.
REQ-031 Scenario: a=7, b=0x1234, k=0 -> o=0x1234, borrow=0, done at cycle 5.
REQ-032 Scenario: a second start is asserted 2 cycles into RUN -> it is ignored, and only one done occurs. A start on the done cycle -> a new operation starts with no gap.
REQ-033 Scenario: rst_n is pulled low during RUN cycle 2 -> all outputs are 0 at once, no done pulse follows, and the next operation completes correctly.
